// File: rtl/mem_model_pkg.sv
// Shared types and sizing helpers for the fixed-latency data memory model.
package mem_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Counter must hold LATENCY-1 for the slower op; never narrower than 1 bit.
    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int max_lat;
        max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return (max_lat <= 1) ? 1 : $clog2(max_lat);
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array: synchronous write, combinational read, no reset.
module mem_array_sp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_words [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_words[rd_idx];

endmodule

// File: rtl/data_memory_model.sv
// Fixed-latency backing store answering the cache controller's mem_read/mem_write
// requests with one mem_ready pulse each, then waiting for the request to drop.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | ready to accept a request
//   ST_WAIT    | latency countdown on the latched request
//   ST_DONE    | mem_ready/mem_err pulse cycle; write committed on entry
//   ST_RELEASE | waiting for the requester to drop mem_read/mem_write
module data_memory_model
    import mem_model_pkg::*;
#(
    parameter int          DEPTH_WORDS   = 1024,
    parameter int          READ_LATENCY  = 4,
    parameter int          WRITE_LATENCY = 4,
    parameter logic [31:0] ERR_RDATA     = ERR_RDATA_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = cnt_width(READ_LATENCY, WRITE_LATENCY);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          op_wr_q, op_wr_d;
    logic          oor_q, oor_d;
    logic          illegal_q, illegal_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          arr_we;
    logic [31:0]   arr_rdata;
    logic          oor_in;
    logic          unused_addr_bits;

    assign oor_in           = |mem_addr[31:2+AW];
    assign unused_addr_bits = ^mem_addr[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        oor_d     = oor_q;
        illegal_d = illegal_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        arr_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read | mem_write) begin
                    state_d   = ST_WAIT;
                    idx_d     = mem_addr[AW+1:2];
                    wdata_d   = mem_wdata;
                    op_wr_d   = mem_write;
                    oor_d     = oor_in;
                    illegal_d = (mem_read & mem_write) | oor_in;
                    cnt_d     = mem_write ? WR_LOAD : RD_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    err_d   = illegal_q;
                    if (op_wr_q) begin
                        arr_we = ~illegal_q;
                    end else if (oor_q) begin
                        rdata_d = ERR_RDATA;
                    end else begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!(mem_read | mem_write)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latches are not reset: they are always reloaded before use.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        idx_q     <= idx_d;
        wdata_q   <= wdata_d;
        op_wr_q   <= op_wr_d;
        oor_q     <= oor_d;
        illegal_q <= illegal_d;
    end

    mem_array_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .wr_en   (arr_we),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_idx  (idx_q),
        .rd_data (arr_rdata)
    );

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/data_memory_model.md
Name: data_memory_model

Overview:
- Word-organised backing store with fixed, parameterised latency. Sits directly downstream of the cache controller and serves its mem_read/mem_write requests.
- Handshake: the requester holds mem_read or mem_write high until it sees mem_ready, then drops it on the following edge.
- Provides one completion pulse per request and enforces request release before accepting new work.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- READ_LATENCY, 4, cycles from request acceptance to mem_ready for reads; minimum 1.
- WRITE_LATENCY, 4, cycles from request acceptance to mem_ready for writes; minimum 1.
- ERR_RDATA, 32'hDEAD_BEEF, value returned on an out-of-range read.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_addr  in  32  byte address; bits [1:0] are ignored.
- mem_read  in  1  read request, level, held until mem_ready.
- mem_write  in  1  write request, level, held until mem_ready.
- mem_wdata  in  32  write data, sampled at acceptance.
- mem_rdata  out  32  read data, valid in the mem_ready cycle, held until next completion.
- mem_ready  out  1  single-cycle completion pulse.
- mem_err  out  1  pulses with mem_ready when the request was out-of-range or had both read and write set.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, clock) -> registered outputs take their reset values; array contents are not cleared.
  - state=IDLE, mem_ready=0, mem_err=0, mem_rdata=0, busy=0, latency counter=0.
  - Reset mid-operation aborts the request; an in-flight write is never committed.
- Word index = mem_addr[2+log2(DEPTH_WORDS)-1:2]. The request is out-of-range when any of mem_addr[31:2+log2(DEPTH_WORDS)] is nonzero.
- States: IDLE, WAIT, DONE, RELEASE.
- IDLE:
  - On any edge with mem_read|mem_write, latch the following and go to WAIT: address, wdata, op (write if mem_write, else read), illegal=(mem_read&mem_write)|out_of_range.
  - Load the counter with LATENCY-1, where LATENCY is the latency of the latched op.
- WAIT: decrement the counter each cycle. When counter==0, go to DONE on that edge.
- Transition into DONE:
  - mem_ready=1 for exactly one cycle.
  - Write, legal: commit wdata to the array in the same edge.
  - Read, legal: mem_rdata=array[index].
  - Out-of-range read: mem_rdata=ERR_RDATA.
  - mem_err=illegal.
  - Illegal requests (both read and write set, or out-of-range) never write the array.
- Net latency: mem_ready rises exactly LATENCY edges after the accepting edge.
- DONE -> RELEASE unconditionally next edge; mem_ready and mem_err return to 0.
- RELEASE:
  - Stay while mem_read|mem_write is high.
  - Go to IDLE on the first edge where both are low.
  - This prevents re-acceptance of a request the requester is still dropping.
- Input changes during WAIT/DONE/RELEASE are ignored; latched values govern the response.
- Minimum back-to-back spacing: a new request is accepted no earlier than the edge after RELEASE observes both requests low.
- Array read is combinational from the registered index, or synchronous with the index presented one cycle early; either is acceptable provided the DONE timing above holds.

Decomposition:
- Shared package mem_model_pkg:
  - state enum (IDLE, WAIT, DONE, RELEASE);
  - ERR_RDATA default;
  - function computing counter width, clog2(max(READ_LATENCY, WRITE_LATENCY)).
- One natural sub-module: mem_array_sp, a single-port 32-bit array of DEPTH_WORDS entries.
  - Inputs: synchronous write enable/index/data; read index. Output: read data.
  - It has no reset.
- Control FSM, latency counter and request latches stay in data_memory_model.

Test Plan:
- Write then read, legal:
  - Stimulus: write 0x1234_5678 to addr 0x0000_0010, hold mem_write until mem_ready; then read addr 0x0000_0013.
  - Response: mem_ready at acceptance+4 for each; rdata=0x1234_5678; mem_err=0.
- Latency check with READ_LATENCY=1, WRITE_LATENCY=7:
  - Stimulus: write, then read.
  - Response: mem_ready exactly 7 and 1 edges after acceptance; mem_ready high one cycle only.
- Held request:
  - Stimulus: requester keeps mem_read high for 3 cycles after mem_ready.
  - Response: no second mem_ready; busy=1 until request drops, then IDLE.
- Out-of-range, DEPTH_WORDS=1024:
  - Stimulus: read addr 0x0000_1000.
  - Response: rdata=0xDEAD_BEEF, mem_err=1 with mem_ready.
  - Stimulus: write 0xFFFF_FFFF to addr 0x0000_1000.
  - Response: mem_err=1, word 0 unchanged.
- Both read and write set:
  - Stimulus: mem_read=mem_write=1, addr 0x20, wdata 0xAAAA_AAAA.
  - Response: mem_err=1; a subsequent read of 0x20 returns the prior value.
- Reset mid-write:
  - Stimulus: assert reset 2 cycles after accepting a write of 0x5555_5555 to 0x40.
  - Response: outputs go to 0 immediately; a later read of 0x40 returns the old value; busy=0.
